// File: rtl/mul_arbiter.sv
// Round-robin front end that shares one modular multiplier among NUM_REQ requesters,
// with a watchdog on the multiplier's finished pulse and per-requester valid/ready responses.
module mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    output logic [NUM_REQ-1:0]           o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]    i_req_a,
    input  logic [NUM_REQ*DATA_W-1:0]    i_req_b,
    output logic [NUM_REQ-1:0]           o_rsp_valid,
    input  logic [NUM_REQ-1:0]           i_rsp_ready,
    output logic [DATA_W-1:0]            o_rsp_data,
    output logic                         o_rsp_err,
    output logic [$clog2(NUM_REQ)-1:0]   o_grant_id,
    output logic                         o_busy,
    output logic                         o_timeout,
    output logic [DATA_W-1:0]            o_mul_a,
    output logic [DATA_W-1:0]            o_mul_b,
    output logic                         o_mul_start,
    input  logic [DATA_W-1:0]            i_mul_result,
    input  logic                         i_mul_finished
);

    localparam int          GW = $clog2(NUM_REQ);
    localparam int          TW = $clog2(TIMEOUT);
    localparam int unsigned NR = NUM_REQ;
    localparam logic [TW-1:0] WD_LAST   = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic [GW-1:0]       last_grant, grant_id, sel, cand;
    logic                found;
    logic [TW-1:0]       wdog;
    logic [DATA_W-1:0]   op_a, op_b, rsp_data;
    logic                rsp_err, timeout_flag;
    logic [DATA_W-1:0]   req_a_arr [NUM_REQ];
    logic [DATA_W-1:0]   req_b_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_a_arr[k] = i_req_a[k*DATA_W +: DATA_W];
        assign req_b_arr[k] = i_req_b[k*DATA_W +: DATA_W];
    end

    // First valid requester after the previous grant, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= NR; i++) begin
            cand = GW'((32'(last_grant) + i) % NR);
            if (!found && i_req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (i_mul_finished || wdog == WD_LAST) state_nxt = RESP;
            RESP:    if (i_rsp_ready[grant_id]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant   <= LAST_INIT;
            grant_id     <= '0;
            op_a         <= '0;
            op_b         <= '0;
            wdog         <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a       <= req_a_arr[sel];
                        op_b       <= req_b_arr[sel];
                        last_grant <= sel;
                        grant_id   <= sel;
                    end
                end
                ISSUE: wdog <= '0;
                WAIT: begin
                    wdog <= wdog + 1'b1;
                    // A finished pulse on the watchdog's last cycle still counts as success.
                    if (i_mul_finished) begin
                        rsp_data <= i_mul_result;
                        rsp_err  <= 1'b0;
                    end else if (wdog == WD_LAST) begin
                        rsp_data     <= '0;
                        rsp_err      <= 1'b1;
                        timeout_flag <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_req_ready = '0;
        o_rsp_valid = '0;
        // Gated by reset so the combinational accept stays low while reset is held.
        if (state == IDLE && found && i_rst_n) o_req_ready = NUM_REQ'(1) << sel;
        if (state == RESP)                    o_rsp_valid = NUM_REQ'(1) << grant_id;
        o_rsp_data  = rsp_data;
        o_rsp_err   = rsp_err;
        o_grant_id  = grant_id;
        o_busy      = (state != IDLE);
        o_timeout   = timeout_flag;
        o_mul_a     = op_a;
        o_mul_b     = op_b;
        o_mul_start = (state == ISSUE);
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Randomized scenario bench for mul_arbiter: a behavioural multiplier with programmable latency
// and an arithmetic reference (a*b mod 2^255-19) supply every expected response.
module tb_mul_arbiter;

    localparam int NR    = 4;
    localparam int DW    = 256;
    localparam int TO    = 16;
    localparam int LIMIT = 60;
    localparam logic [511:0] PRIME = (512'd1 << 255) - 512'd19;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_a = '0;
    logic [NR*DW-1:0]  req_b = '0;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready = '0;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic [1:0]        grant_id;
    logic              busy;
    logic              timeout;
    logic [DW-1:0]     mul_a, mul_b;
    logic              mul_start;
    logic [DW-1:0]     mul_result;
    logic              mul_finished;

    logic              model_fin = 1'b0;
    logic [DW-1:0]     model_res = '0;
    logic              spur_fin = 1'b0;
    logic [DW-1:0]     spur_res = '0;
    int                mul_lat = 10;
    bit                never_finish = 1'b0;

    int total = 0;
    int bad   = 0;

    assign mul_finished = model_fin | spur_fin;
    assign mul_result   = spur_fin ? spur_res : model_res;

    mul_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_a(req_a), .i_req_b(req_b),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
        .o_grant_id(grant_id), .o_busy(busy), .o_timeout(timeout),
        .o_mul_a(mul_a), .o_mul_b(mul_b), .o_mul_start(mul_start),
        .i_mul_result(mul_result), .i_mul_finished(mul_finished)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [DW-1:0] mulmod(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [511:0] prod;
        prod = {256'd0, a} * {256'd0, b};
        prod = prod % PRIME;
        return prod[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural multiplier: result appears mul_lat cycles after the start pulse is seen.
    initial begin
        int          cnt;
        bit          pending;
        logic [DW-1:0] pend_res;
        cnt = 0;
        pending = 1'b0;
        pend_res = '0;
        forever begin
            @(posedge clk); #1;
            model_fin = 1'b0;
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    model_fin = 1'b1;
                    model_res = pend_res;
                    pending   = 1'b0;
                end
            end
            if (mul_start === 1'b1 && !never_finish) begin
                pending  = 1'b1;
                cnt      = mul_lat;
                pend_res = mulmod(mul_a, mul_b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic set_req(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[k*DW +: DW] = a;
        req_b[k*DW +: DW] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        never_finish = 1'b0;
        spur_fin = 1'b0;
        mul_lat = 10;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < LIMIT) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        @(negedge clk);
        while (rsp_valid == '0 && n < LIMIT) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
    endtask

    // Requests one job from requester k alone; returns at the negedge of its response cycle.
    task automatic issue_job(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input int lat, output logic [NR-1:0] rdy, output int nr, output int ns);
        set_req(k, a, b);
        mul_lat = lat;
        req_valid = '0;
        req_valid[k] = 1'b1;
        wait_ready(nr);
        rdy = req_ready;
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(ns);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0000", rsp_valid); end
        total++; if (rsp_data !== '0 || rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp got=%0h/%b exp=0/0", rsp_data, rsp_err); end
        total++; if (grant_id !== 2'd0 || busy !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL rst_status got=%0d/%b/%b exp=0/0/0", grant_id, busy, timeout); end
        total++; if (mul_start !== 1'b0 || mul_a !== '0 || mul_b !== '0) begin bad++; $display("FAIL rst_mul got=%b/%0h/%0h exp=0/0/0", mul_start, mul_a, mul_b); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_first_grant got=%b exp=0001", req_ready); end
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_dropped_req busy got=%b exp=0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int n;
        mul_lat = 10;
        rsp_ready = 4'b0001;
        set_req(0, 256'd3, 256'd5);
        req_valid = 4'b0001;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001 || busy !== 1'b0) begin bad++; $display("FAIL single_ready got=%b/%b exp=0001/0", req_ready, busy); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        total++; if (mul_start !== 1'b1 || mul_a !== 256'd3 || mul_b !== 256'd5) begin bad++; $display("FAIL single_issue got=%b/%0h/%0h exp=1/3/5", mul_start, mul_a, mul_b); end
        total++; if (req_ready !== 4'b0000 || grant_id !== 2'd0 || busy !== 1'b1) begin bad++; $display("FAIL single_issue_status got=%b/%0d/%b exp=0000/0/1", req_ready, grant_id, busy); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (mul_start !== 1'b0) begin bad++; $display("FAIL single_start_pulse got=%b exp=0", mul_start); end
        @(posedge clk); #1;
        wait_rsp(n);
        total++; if (n !== 9) begin bad++; $display("FAIL single_latency got=%0d exp=9", n); end
        total++; if (rsp_valid !== 4'b0001 || rsp_data !== 256'd15 || rsp_err !== 1'b0) begin bad++; $display("FAIL single_rsp got=%b/%0h/%b exp=0001/f/0", rsp_valid, rsp_data, rsp_err); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin bad++; $display("FAIL single_idle got=%b/%b exp=0/0000", busy, rsp_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] ra [NR];
        logic [DW-1:0] rb [NR];
        logic [DW-1:0] ea, eb;
        logic [NR-1:0] onehot;
        int n, prev, exp_g;
        do_reset();
        rsp_ready = '1;
        prev = NR - 1;
        for (int k = 0; k < NR; k++) begin
            ra[k] = rand256();
            rb[k] = rand256();
            set_req(k, ra[k], rb[k]);
        end
        req_valid = '1;
        for (int j = 0; j < 6; j++) begin
            exp_g = (prev + 1) % NR;
            onehot = 4'b0001 << exp_g;
            mul_lat = int'($urandom_range(1, 8));
            wait_ready(n);
            total++; if (req_ready !== onehot) begin bad++; $display("FAIL rr_grant job=%0d got=%b exp=%b", j, req_ready, onehot); end
            ea = ra[exp_g];
            eb = rb[exp_g];
            @(posedge clk); #1;
            ra[exp_g] = rand256();
            rb[exp_g] = rand256();
            set_req(exp_g, ra[exp_g], rb[exp_g]);
            @(negedge clk);
            total++; if (grant_id !== 2'(exp_g) || mul_start !== 1'b1 || mul_a !== ea || mul_b !== eb) begin bad++; $display("FAIL rr_issue job=%0d id=%0d exp_id=%0d start=%b", j, grant_id, exp_g, mul_start); end
            @(posedge clk); #1;
            wait_rsp(n);
            total++; if (rsp_valid !== onehot || rsp_data !== mulmod(ea, eb) || rsp_err !== 1'b0) begin bad++; $display("FAIL rr_rsp job=%0d got=%b/%0h exp=%b/%0h", j, rsp_valid, rsp_data, onehot, mulmod(ea, eb)); end
            total++; if (mul_a !== ea || mul_b !== eb) begin bad++; $display("FAIL rr_operand_hold job=%0d got=%0h exp=%0h", j, mul_a, ea); end
            prev = exp_g;
            @(posedge clk); #1;
        end
        req_valid = '0;
    endtask

    task automatic test_back_to_back_backpressure();
        logic [DW-1:0] a1, b1, a2, b2, ed;
        int n;
        do_reset();
        a1 = rand256(); b1 = rand256();
        a2 = rand256(); b2 = rand256();
        set_req(2, a2, b2);
        mul_lat = int'($urandom_range(2, 8));
        req_valid = 4'b0100;
        rsp_ready = 4'b1011;
        wait_ready(n);
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_grant2 got=%b exp=0100", req_ready); end
        @(posedge clk); #1;
        set_req(1, a1, b1);
        req_valid = 4'b0010;
        wait_rsp(n);
        ed = mulmod(a2, b2);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                @(negedge clk);
            end
            total++; if (rsp_valid !== 4'b0100 || rsp_data !== ed || req_ready !== 4'b0000) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b/%0h/%b exp=0100/%0h/0000", i, rsp_valid, rsp_data, req_ready, ed); end
        end
        @(posedge clk); #1;
        rsp_ready = 4'b1111;
        @(negedge clk);
        total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL bp_last_resp got=%b exp=0100", rsp_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (req_ready !== 4'b0010 || rsp_valid !== 4'b0000) begin bad++; $display("FAIL bp_next_grant got=%b/%b exp=0010/0000", req_ready, rsp_valid); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        total++; if (grant_id !== 2'd1 || mul_a !== a1 || mul_b !== b1) begin bad++; $display("FAIL bp_issue1 got=%0d exp=1", grant_id); end
        @(posedge clk); #1;
        wait_rsp(n);
        total++; if (rsp_valid !== 4'b0010 || rsp_data !== mulmod(a1, b1)) begin bad++; $display("FAIL bp_rsp1 got=%b/%0h exp=0010/%0h", rsp_valid, rsp_data, mulmod(a1, b1)); end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        logic [NR-1:0] rdy;
        logic [DW-1:0] a, b;
        int nr, ns;
        do_reset();
        rsp_ready = '1;
        a = rand256(); b = rand256();
        issue_job(3, a, b, 5, rdy, nr, ns);
        total++; if (rsp_data !== mulmod(a, b) || rsp_err !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL to_prejob got=%0h/%b/%b exp=%0h/0/0", rsp_data, rsp_err, timeout, mulmod(a, b)); end
        @(posedge clk); #1;
        never_finish = 1'b1;
        issue_job(0, rand256(), rand256(), 5, rdy, nr, ns);
        total++; if (ns !== TO + 1) begin bad++; $display("FAIL to_latency got=%0d exp=%0d", ns, TO + 1); end
        total++; if (rsp_valid !== 4'b0001 || rsp_data !== '0 || rsp_err !== 1'b1 || timeout !== 1'b1) begin bad++; $display("FAIL to_rsp got=%b/%0h/%b/%b exp=0001/0/1/1", rsp_valid, rsp_data, rsp_err, timeout); end
        @(posedge clk); #1;
        never_finish = 1'b0;
        a = rand256(); b = rand256();
        issue_job(1, a, b, TO, rdy, nr, ns);
        total++; if (ns !== TO + 1 || rsp_err !== 1'b0 || rsp_data !== mulmod(a, b)) begin bad++; $display("FAIL to_edge_finish_wins got=%0d/%b/%0h exp=%0d/0/%0h", ns, rsp_err, rsp_data, TO + 1, mulmod(a, b)); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_sticky1 got=%b exp=1", timeout); end
        @(posedge clk); #1;
        issue_job(2, rand256(), rand256(), TO + 1, rdy, nr, ns);
        total++; if (ns !== TO + 1 || rsp_err !== 1'b1 || rsp_data !== '0) begin bad++; $display("FAIL to_late_finish got=%0d/%b/%0h exp=%0d/1/0", ns, rsp_err, rsp_data, TO + 1); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || rsp_data !== '0 || rsp_valid !== 4'b0000) begin bad++; $display("FAIL to_late_ignored got=%b/%0h/%b exp=0/0/0000", busy, rsp_data, rsp_valid); end
        @(posedge clk); #1;
        a = rand256(); b = rand256();
        issue_job(3, a, b, 3, rdy, nr, ns);
        total++; if (rsp_err !== 1'b0 || rsp_data !== mulmod(a, b) || timeout !== 1'b1) begin bad++; $display("FAIL to_sticky2 got=%b/%0h/%b exp=0/%0h/1", rsp_err, rsp_data, timeout, mulmod(a, b)); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        logic [NR-1:0] rdy;
        logic [DW-1:0] a, b;
        int nr, ns;
        do_reset();
        rsp_ready = '1;
        issue_job(1, rand256(), rand256(), 4, rdy, nr, ns);
        @(posedge clk); #1;
        set_req(1, rand256(), rand256());
        mul_lat = 10;
        req_valid = 4'b0010;
        wait_ready(nr);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || rsp_valid !== 4'b0000 || req_ready !== 4'b0000 || mul_start !== 1'b0) begin bad++; $display("FAIL rmw_ctrl got=%b/%b/%b/%b exp=0/0000/0000/0", busy, rsp_valid, req_ready, mul_start); end
        total++; if (rsp_data !== '0 || rsp_err !== 1'b0 || grant_id !== 2'd0 || timeout !== 1'b0 || mul_a !== '0 || mul_b !== '0) begin bad++; $display("FAIL rmw_data got=%0h/%b/%0d exp=0/0/0", rsp_data, rsp_err, grant_id); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rmw_no_rsp cyc=%0d got=%b/%b exp=0000/0", i, rsp_valid, busy); end
            @(posedge clk); #1;
        end
        a = rand256(); b = rand256();
        set_req(0, a, b);
        set_req(2, rand256(), rand256());
        mul_lat = 4;
        req_valid = 4'b0101;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmw_regrant got=%b exp=0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(ns);
        total++; if (rsp_valid !== 4'b0001 || rsp_data !== mulmod(a, b)) begin bad++; $display("FAIL rmw_rsp got=%b/%0h exp=0001/%0h", rsp_valid, rsp_data, mulmod(a, b)); end
        @(posedge clk); #1;
    endtask

    task automatic test_spurious();
        int n;
        do_reset();
        spur_res = rand256();
        spur_fin = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || rsp_data !== '0 || rsp_valid !== 4'b0000) begin bad++; $display("FAIL spur_idle got=%b/%0h/%b exp=0/0/0000", busy, rsp_data, rsp_valid); end
        @(posedge clk); #1;
        spur_fin = 1'b0;
        set_req(0, 256'd7, 256'd9);
        mul_lat = 6;
        req_valid = 4'b0001;
        wait_ready(n);
        @(posedge clk); #1;
        req_valid = '0;
        spur_fin = 1'b1;
        @(negedge clk);
        total++; if (mul_start !== 1'b1) begin bad++; $display("FAIL spur_issue_state got=%b exp=1", mul_start); end
        @(posedge clk); #1;
        spur_fin = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b1 || rsp_valid !== 4'b0000) begin bad++; $display("FAIL spur_issue_ignored got=%b/%b exp=1/0000", busy, rsp_valid); end
        @(posedge clk); #1;
        wait_rsp(n);
        total++; if (n !== 5 || rsp_valid !== 4'b0001 || rsp_data !== 256'd63 || rsp_err !== 1'b0) begin bad++; $display("FAIL spur_job got=%0d/%b/%0h exp=5/0001/3f", n, rsp_valid, rsp_data); end
        @(posedge clk); #1;
        spur_fin = 1'b1;
        @(negedge clk);
        total++; if (rsp_valid !== 4'b0001 || rsp_data !== 256'd63 || rsp_err !== 1'b0) begin bad++; $display("FAIL spur_resp got=%b/%0h/%b exp=0001/3f/0", rsp_valid, rsp_data, rsp_err); end
        @(posedge clk); #1;
        spur_fin = 1'b0;
        rsp_ready = 4'b0001;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || rsp_data !== 256'd63) begin bad++; $display("FAIL spur_done got=%b/%0h exp=0/3f", busy, rsp_data); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back_backpressure();
        test_timeout();
        test_reset_mid_wait();
        test_spurious();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one modular multiplier (256-bit operands, start/finished handshake, result mod 2^255-19) among NUM_REQ requesters, e.g. point-add and inversion engines.
- Round-robin arbitration; each granted job is one multiplier operation.
- Captures operands, pulses start, waits for finished with a watchdog, and returns the result to the owning requester through a valid/ready response.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- DATA_W, 256, operand/result width
- TIMEOUT, 1024, max WAIT cycles before abort (>=2)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  NUM_REQ  per-requester request
- o_req_ready  out  NUM_REQ  one-hot accept
- i_req_a  in  NUM_REQ*DATA_W  operand A; requester k uses slice [k*DATA_W +: DATA_W]
- i_req_b  in  NUM_REQ*DATA_W  operand B, same packing
- o_rsp_valid  out  NUM_REQ  one-hot response valid
- i_rsp_ready  in  NUM_REQ  per-requester response accept
- o_rsp_data  out  DATA_W  result (shared bus)
- o_rsp_err  out  1  response caused by timeout
- o_grant_id  out  $clog2(NUM_REQ)  index of current/last grant
- o_busy  out  1  FSM not in IDLE
- o_timeout  out  1  sticky timeout flag
- o_mul_a  out  DATA_W  multiplier operand A
- o_mul_b  out  DATA_W  multiplier operand B
- o_mul_start  out  1  one-cycle start pulse
- i_mul_result  in  DATA_W  multiplier result
- i_mul_finished  in  1  multiplier done pulse

Behaviour:
- Reset (async, i_rst_n=0):
  - All outputs 0; FSM=IDLE.
  - last_grant=NUM_REQ-1, so requester 0 wins first; watchdog counter 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Pick the first valid requester scanning last_grant+1, +2, ... modulo NUM_REQ.
  - o_req_ready[g]=1 combinationally in this cycle only; the handshake completes at the edge.
  - At the edge: latch a/b into operand regs, update last_grant and o_grant_id, go ISSUE.
  - No valid: stay; o_req_ready=0.
- ISSUE:
  - o_mul_start=1 for exactly this cycle.
  - o_mul_a/o_mul_b driven from the latched regs.
  - Clear watchdog; go WAIT.
  - i_mul_finished in this cycle is ignored.
- WAIT:
  - Watchdog increments each cycle.
  - i_mul_finished=1: latch i_mul_result into o_rsp_data, o_rsp_err=0, go RESP.
  - Watchdog reaching TIMEOUT-1 without finished: o_rsp_data=0, o_rsp_err=1, o_timeout=1 (sticky until reset), go RESP.
  - finished on the same cycle as the timeout: finished wins.
- RESP:
  - o_rsp_valid[g]=1; o_rsp_data and o_rsp_err held stable.
  - On i_rsp_ready[g]=1: go IDLE, drop valid next cycle.
  - i_rsp_ready of other requesters is ignored.
- Operand hold: o_mul_a/b hold the last latched operands until the next grant; never change during ISSUE/WAIT.
- i_mul_finished outside WAIT is ignored, with no state change.
- No new grant while busy: o_req_ready=0 in ISSUE/WAIT/RESP.
- A requester may drop i_req_valid before grant; the arbiter evaluates it only in IDLE.
- Latency:
  - Handshake edge T → start high in cycle T+1.
  - finished sampled in cycle F → o_rsp_valid high from F+1.
  - Best case with ready tied high: one job per (mul latency + 3) cycles.
- o_busy = (state != IDLE).
- Reset mid-operation (any state): immediate return to IDLE with reset values; an in-flight result arriving later is ignored.

Test Plan:
- Single request:
  - Stimulus: req0 a=3, b=5; model multiplier returns 15 after 10 cycles.
  - Response: o_req_ready=0001 for one cycle; o_mul_start one pulse at T+1; o_rsp_valid=0001 with data=15, err=0; IDLE after ready.
- Round-robin:
  - Stimulus: all four valid continuously from reset, rsp_ready tied 1.
  - Response: grant order 0,1,2,3,0,1; o_grant_id matches; no requester granted twice before the others.
- Response backpressure:
  - Stimulus: i_rsp_ready[2]=0 for 6 cycles while req1 is valid.
  - Response: o_rsp_valid=0100 and data stable all 6 cycles; o_req_ready=0.
  - After ready: req1 granted on the next IDLE cycle.
- Timeout:
  - Stimulus: TIMEOUT=16, model never finishes.
  - Response: after 16 WAIT cycles, o_rsp_valid set with data=0 and err=1; o_timeout=1 and stays 1 through later jobs until reset.
- Reset mid-WAIT:
  - Stimulus: assert i_rst_n=0 at WAIT cycle 4, release; model raises finished 3 cycles later.
  - Response: all outputs 0, no response emitted; next grant goes to requester 0.
- Spurious finished:
  - Stimulus: i_mul_finished pulses in IDLE, ISSUE and RESP.
  - Response: no state change, o_rsp_data unchanged; the real job result (a=7, b=9 → 63) is still delivered correctly.
